cpu_mem_bridge: RTL

- Synthesizable bus bridge directly downstream of top8227; replaces the bench's behavioural byte-array memory on the processor side.
- Converts the CPU's per-cycle address/data/readNotWrite bus into a req/ack handshake toward an external SRAM or ROM controller.
- Stalls the CPU through its ready input until each access completes.
- Adds a per-access timeout that returns an open-bus value and flags an error.

---
 rtl/cpu_mem_bridge_pkg.sv | 19 +
 rtl/cpu_mem_bridge_if.sv | 29 ++
 rtl/cpu_mem_bridge_timeout_ctr.sv | 28 ++
 rtl/cpu_mem_bridge.sv | 113 +++++++++++
 4 files changed

// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } bridge_state_t;

   localparam logic [15:0] RESET_VEC_LO_ADDR = 16'hFFFC;
   localparam logic [15:0] RESET_VEC_HI_ADDR = 16'hFFFD;

   typedef struct packed {
      logic [15:0] addr;
      logic        we;
      logic [7:0]  wdata;
   } bus_access_t;

endpackage

// File: rtl/cpu_mem_bridge_if.sv
// Request/acknowledge bus between the bridge (master) and an SRAM/ROM controller (slave).
interface cpu_mem_bridge_if;

   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ack
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ack
   );

endinterface

// File: rtl/cpu_mem_bridge_timeout_ctr.sv
// 8-bit saturating wait counter; terminal flags the last permitted wait cycle.
module bridge_timeout_ctr #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic terminal
);

   localparam logic [7:0] TERMINAL_COUNT = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != 8'hFF)) begin
         count <= count + 8'd1;
      end
   end

   assign terminal = (count == TERMINAL_COUNT);

endmodule

// File: rtl/cpu_mem_bridge.sv
// Converts the CPU's per-cycle bus into a req/ack memory access, stalling the CPU via ready.
// Optional macro BRIDGE_VECTOR_OVERRIDE_EN serves RESET_VECTOR for reads of 16'hFFFC/16'hFFFD.
module cpu_mem_bridge
   import cpu_bus_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 16,
   parameter logic [7:0]  OPEN_BUS_VALUE = 8'hFF,
   parameter logic [15:0] RESET_VECTOR   = 16'hCCDD
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         AddressBusHigh,
   input  logic [7:0]         AddressBusLow,
   input  logic               readNotWrite,
   input  logic [7:0]         dataBusOutput,
   output logic [7:0]         dataBusInput,
   output logic               ready,
   cpu_mem_bridge_if.master   mem,
   output logic               bus_error
);

`ifdef BRIDGE_VECTOR_OVERRIDE_EN
   localparam bit VECTOR_OVERRIDE = 1'b1;
`else
   localparam bit VECTOR_OVERRIDE = 1'b0;
`endif

   bridge_state_t state;
   bridge_state_t state_next;
   bus_access_t   access;
   bus_access_t   access_next;
   logic [7:0]    rdata_next;
   logic          error_next;
   logic          ctr_terminal;
   logic          vector_hit;
   logic [15:0]   cpu_addr;

   assign cpu_addr   = {AddressBusHigh, AddressBusLow};
   assign vector_hit = VECTOR_OVERRIDE && readNotWrite &&
                       ((cpu_addr == RESET_VEC_LO_ADDR) || (cpu_addr == RESET_VEC_HI_ADDR));

   bridge_timeout_ctr #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk      (clk),
      .rst      (rst),
      .clear    (state == IDLE),
      .enable   (state == REQ),
      .terminal (ctr_terminal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         access       <= '0;
         dataBusInput <= '0;
         bus_error    <= 1'b0;
      end else begin
         state        <= state_next;
         access       <= access_next;
         dataBusInput <= rdata_next;
         bus_error    <= error_next;
      end
   end

   // An ack arriving on the terminal wait cycle still completes the access cleanly.
   always_comb begin
      state_next  = state;
      access_next = access;
      rdata_next  = dataBusInput;
      error_next  = 1'b0;
      case (state)
         IDLE: begin
            access_next.addr  = cpu_addr;
            access_next.we    = ~readNotWrite;
            access_next.wdata = dataBusOutput;
            if (vector_hit) begin
               rdata_next = cpu_addr[0] ? RESET_VECTOR[15:8] : RESET_VECTOR[7:0];
               state_next = DONE;
            end else begin
               state_next = REQ;
            end
         end
         REQ: begin
            if (mem.mem_ack) begin
               if (!access.we) begin
                  rdata_next = mem.mem_rdata;
               end
               state_next = DONE;
            end else if (ctr_terminal) begin
               if (!access.we) begin
                  rdata_next = OPEN_BUS_VALUE;
               end
               error_next = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign ready         = (state != REQ);
   assign mem.mem_req   = (state == REQ);
   assign mem.mem_we    = access.we;
   assign mem.mem_addr  = access.addr;
   assign mem.mem_wdata = access.wdata;

endmodule
